// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks a register list and issues one memory beat per register.
// Define LDM_STM_PC_EN to let LDM load r15 through pc_we/pc_wd; otherwise r15 is dropped from LDM lists.
module ldm_stm_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_load,
    input  logic        p_bit,
    input  logic        u_bit,
    input  logic        wback,
    input  logic [3:0]  rn,
    input  logic [31:0] base,
    input  logic [15:0] reglist,
    output logic [3:0]  ra,
    input  logic [31:0] rd,
    output logic        we,
    output logic [3:0]  wa,
    output logic [31:0] wd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        pc_we,
    output logic [31:0] pc_wd,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 4;
    localparam int unsigned LW = 16;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [LW-1:0]   list_q;
    logic [DW-1:0]   addr_q;
    logic [DW-1:0]   final_q;
    logic            load_q;
    logic            wb_q;
    logic [RW-1:0]   rn_q;

    logic [LW-1:0]   list_in;
    logic [CW-1:0]   cnt_in;
    logic [DW-1:0]   span;
    logic [DW-1:0]   addr_in;
    logic [DW-1:0]   final_in;
    logic            wb_in;
    logic [RW-1:0]   cur;
    logic [LW-1:0]   list_nxt;
    logic            pc_hit;

    function automatic logic [CW-1:0] popcount(input logic [LW-1:0] v);
        popcount = '0;
        for (int i = 0; i < int'(LW); i++) popcount = popcount + CW'(v[i]);
    endfunction

    function automatic logic [RW-1:0] lowest(input logic [LW-1:0] v);
        lowest = '0;
        for (int i = int'(LW) - 1; i >= 0; i--) if (v[i]) lowest = RW'(i);
    endfunction

    // Start-time decode: effective list, beat count, first address, final base
    always_comb begin
`ifdef LDM_STM_PC_EN
        list_in = reglist;
`else
        list_in = {reglist[15] & ~is_load, reglist[14:0]};
`endif
        cnt_in = popcount(list_in);
        span   = DW'({cnt_in, 2'b00});
        case ({p_bit, u_bit})
            2'b01:   addr_in = base;
            2'b11:   addr_in = base + DW'(4);
            2'b00:   addr_in = base - span + DW'(4);
            default: addr_in = base - span;
        endcase
        final_in = u_bit ? (base + span) : (base - span);
        // A loaded base wins over write-back; r15 is never written back
        wb_in    = wback && (rn != 4'hF) && !(is_load && list_in[rn]);
    end

    always_comb begin
        cur      = lowest(list_q);
        list_nxt = list_q & (list_q - LW'(1));
`ifdef LDM_STM_PC_EN
        pc_hit   = (cur == 4'hF);
`else
        pc_hit   = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            list_q  <= '0;
            addr_q  <= '0;
            final_q <= '0;
            load_q  <= 1'b0;
            wb_q    <= 1'b0;
            rn_q    <= '0;
        end else if (state == S_IDLE && start) begin
            list_q  <= list_in;
            addr_q  <= addr_in;
            final_q <= final_in;
            load_q  <= is_load;
            wb_q    <= wb_in;
            rn_q    <= rn;
        end else if (state == S_XFER && mem_ack) begin
            list_q  <= list_nxt;
            addr_q  <= addr_q + DW'(4);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (cnt_in == '0) ? S_DONE : S_XFER;
            S_XFER: if (mem_ack && list_nxt == '0) state_nxt = wb_q ? S_WB : S_DONE;
            S_WB:   state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ra        = '0;
        we        = 1'b0;
        wa        = '0;
        wd        = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        pc_we     = 1'b0;
        pc_wd     = '0;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        case (state)
            S_XFER: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (!load_q) begin
                    mem_we    = 1'b1;
                    ra        = cur;
                    mem_wdata = rd;
                end else if (mem_ack) begin
                    if (pc_hit) begin
                        pc_we = 1'b1;
                        pc_wd = mem_rdata;
                    end else begin
                        we = 1'b1;
                        wa = cur;
                        wd = mem_rdata;
                    end
                end
            end
            S_WB: begin
                we = 1'b1;
                wa = rn_q;
                wd = final_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed self-checking bench for ldm_stm_seq; builds with or without LDM_STM_PC_EN.
module tb_ldm_stm_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        p_bit = 1'b0;
    logic        u_bit = 1'b0;
    logic        wback = 1'b0;
    logic [3:0]  rn = '0;
    logic [31:0] base = '0;
    logic [15:0] reglist = '0;
    logic [3:0]  ra;
    logic [31:0] rd;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack = 1'b0;
    logic        pc_we;
    logic [31:0] pc_wd;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    ldm_stm_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .is_load(is_load),
        .p_bit(p_bit), .u_bit(u_bit), .wback(wback), .rn(rn), .base(base),
        .reglist(reglist), .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc_we(pc_we), .pc_wd(pc_wd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Regfile and memory models: distinct, predictable data per register / address
    assign rd        = (ra == 4'hF) ? 32'h0000_1008 : (32'hD000_0000 | 32'(ra));
    assign mem_rdata = mem_addr ^ 32'h5A5A_0000;

    logic [64:0] xq[$];
    logic [35:0] wq[$];
    logic [31:0] pq[$];
    int          req_cycles = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          addr_moves = 0;
    int          cyc = 0;
    int          wait_n = 0;
    int          wcnt = 0;
    logic        pend = 1'b0;
    logic [31:0] paddr = '0;

    // Ack responder plus mid-cycle recorder of every observable event
    always @(negedge clk) begin
        if (mem_req && wcnt == wait_n) begin
            mem_ack = 1'b1;
            wcnt = 0;
        end else if (mem_req) begin
            mem_ack = 1'b0;
            wcnt++;
        end else begin
            mem_ack = 1'b0;
            wcnt = 0;
        end
        #1;
        if (pend && mem_req && mem_addr !== paddr) addr_moves++;
        pend  = mem_req && !mem_ack;
        paddr = mem_addr;
        if (mem_req) req_cycles++;
        if (mem_req && mem_ack) xq.push_back({mem_we, mem_addr, mem_wdata});
        if (we) wq.push_back({wa, wd});
        if (pc_we) pq.push_back(pc_wd);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
    end

    task automatic clear_logs();
        xq.delete(); wq.delete(); pq.delete();
        req_cycles = 0; done_cnt = 0; done_cyc = -1; addr_moves = 0;
    endtask

    // Launch one operation and wait (bounded) for done; lat is -1 on timeout
    task automatic run_op(input logic ld, input logic pb, input logic ub, input logic wbk,
                          input logic [3:0] rn_i, input logic [31:0] base_i,
                          input logic [15:0] list_i, input int wt, input int stray_at,
                          output int lat);
        int c0;
        @(negedge clk); #2;
        clear_logs();
        wait_n = wt;
        is_load = ld; p_bit = pb; u_bit = ub; wback = wbk;
        rn = rn_i; base = base_i; reglist = list_i;
        start = 1'b1;
        c0 = cyc - 1;
        for (int k = 0; k < 300 && done_cnt == 0; k++) begin
            @(negedge clk); #2;
            start = (k == stray_at);
            if (k == stray_at) reglist = 16'hFFFF;
        end
        start = 1'b0;
        lat = (done_cnt == 0) ? -1 : done_cyc - c0;
    endtask

    task automatic test_reset();
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        tests++; if (we !== 1'b0 || pc_we !== 1'b0) begin fails++; $display("FAIL reset_we: got we=%b pc_we=%b want 0", we, pc_we); end
        tests++; if (mem_addr !== 32'h0 || wd !== 32'h0) begin fails++; $display("FAIL reset_data: got addr=%h wd=%h want 0", mem_addr, wd); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #2;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_stm_ia_wb();
        int lat;
        logic [64:0] ex[3];
        logic [64:0] got;
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 32'h100, 16'h000E, 0, -1, lat);
        ex[0] = {1'b1, 32'h100, 32'hD000_0001};
        ex[1] = {1'b1, 32'h104, 32'hD000_0002};
        ex[2] = {1'b1, 32'h108, 32'hD000_0003};
        tests++; if (xq.size() != 3) begin fails++; $display("FAIL stm_ia_count: got %0d want 3", xq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < xq.size()) ? xq[i] : '1;
            tests++; if (got !== ex[i]) begin fails++; $display("FAIL stm_ia_beat%0d: got %h want %h", i, got, ex[i]); end
        end
        tests++; if (wq.size() != 1 || wq[0] !== {4'd0, 32'h10C}) begin fails++; $display("FAIL stm_ia_wb: got n=%0d want one write r0=0000010c", wq.size()); end
        tests++; if (lat != 5) begin fails++; $display("FAIL stm_ia_latency: got %0d want 5", lat); end
    endtask

    task automatic test_ldm_db_pc();
        int lat;
        int nw;
        int np;
        int el;
        logic [35:0] ew[2];
        logic [35:0] got;
`ifdef LDM_STM_PC_EN
        ew[0] = {4'd0, 32'h5A5A_01F4};
        ew[1] = {4'd1, 32'h5A5A_01F8};
        nw = 2; np = 1; el = 10;
`else
        ew[0] = {4'd0, 32'h5A5A_01F8};
        ew[1] = {4'd1, 32'h5A5A_01FC};
        nw = 2; np = 0; el = 7;
`endif
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 32'h200, 16'h8003, 2, -1, lat);
        tests++; if (wq.size() != nw) begin fails++; $display("FAIL ldm_db_writes: got %0d want %0d", wq.size(), nw); end
        for (int i = 0; i < 2; i++) begin
            got = (i < wq.size()) ? wq[i] : '1;
            tests++; if (got !== ew[i]) begin fails++; $display("FAIL ldm_db_load%0d: got %h want %h", i, got, ew[i]); end
        end
        tests++; if (pq.size() != np) begin fails++; $display("FAIL ldm_db_pc_we: got %0d pulses want %0d", pq.size(), np); end
`ifdef LDM_STM_PC_EN
        tests++; if (pq.size() > 0 && pq[0] !== 32'h5A5A_01FC) begin fails++; $display("FAIL ldm_db_pc_wd: got %h want 5a5a01fc", pq[0]); end
`endif
        tests++; if (addr_moves != 0) begin fails++; $display("FAIL ldm_db_addr_stable: got %0d changes want 0", addr_moves); end
        tests++; if (lat != el) begin fails++; $display("FAIL ldm_db_latency: got %0d want %0d", lat, el); end
    endtask

    task automatic test_ldm_ib_rn_in_list();
        int lat;
        logic [35:0] got;
        run_op(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 32'h300, 16'h0006, 0, -1, lat);
        tests++; if (wq.size() != 2) begin fails++; $display("FAIL ldm_ib_writes: got %0d want 2", wq.size()); end
        got = (wq.size() > 0) ? wq[0] : '1;
        tests++; if (got !== {4'd1, 32'h5A5A_0304}) begin fails++; $display("FAIL ldm_ib_r1: got %h want 15a5a0304", got); end
        got = (wq.size() > 1) ? wq[1] : '1;
        tests++; if (got !== {4'd2, 32'h5A5A_0308}) begin fails++; $display("FAIL ldm_ib_r2: got %h want 25a5a0308", got); end
        tests++; if (lat != 3) begin fails++; $display("FAIL ldm_ib_latency: got %0d want 3", lat); end
    endtask

    task automatic test_empty_list();
        int lat;
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'h700, 16'h0000, 0, -1, lat);
        tests++; if (req_cycles != 0 || wq.size() != 0) begin fails++; $display("FAIL empty_activity: got req=%0d we=%0d want 0 0", req_cycles, wq.size()); end
        tests++; if (lat != 1) begin fails++; $display("FAIL empty_latency: got %0d want 1", lat); end
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 32'h740, 16'h8000, 0, -1, lat);
`ifdef LDM_STM_PC_EN
        tests++; if (pq.size() != 1 || lat != 2) begin fails++; $display("FAIL ldm_r15_only: got pc=%0d lat=%0d want 1 2", pq.size(), lat); end
`else
        tests++; if (req_cycles != 0 || pq.size() != 0 || lat != 1) begin fails++; $display("FAIL ldm_r15_masked: got req=%0d pc=%0d lat=%0d want 0 0 1", req_cycles, pq.size(), lat); end
`endif
    endtask

    task automatic test_wrap();
        int lat;
        logic [64:0] got;
        run_op(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'hFFFF_FFFC, 16'h0030, 0, -1, lat);
        got = (xq.size() > 0) ? xq[0] : '0;
        tests++; if (got !== {1'b1, 32'hFFFF_FFFC, 32'hD000_0004}) begin fails++; $display("FAIL wrap_beat0: got %h want 1fffffffcd0000004", got); end
        got = (xq.size() > 1) ? xq[1] : '1;
        tests++; if (got !== {1'b1, 32'h0000_0000, 32'hD000_0005}) begin fails++; $display("FAIL wrap_beat1: got %h want 100000000d0000005", got); end
        tests++; if (lat != 3) begin fails++; $display("FAIL wrap_latency: got %0d want 3", lat); end
    endtask

    task automatic test_da_wb();
        int lat;
        logic [64:0] got;
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'h400, 16'h0101, 0, -1, lat);
        got = (xq.size() > 0) ? xq[0] : '1;
        tests++; if (got !== {1'b1, 32'h3FC, 32'hD000_0000}) begin fails++; $display("FAIL da_beat0: got %h want 1000003fcd0000000", got); end
        got = (xq.size() > 1) ? xq[1] : '1;
        tests++; if (got !== {1'b1, 32'h400, 32'hD000_0008}) begin fails++; $display("FAIL da_beat1: got %h want 100000400d0000008", got); end
        tests++; if (wq.size() != 1 || wq[0] !== {4'd1, 32'h3F8}) begin fails++; $display("FAIL da_wb: got n=%0d want one write r1=000003f8", wq.size()); end
        tests++; if (lat != 4) begin fails++; $display("FAIL da_latency: got %0d want 4", lat); end
    endtask

    task automatic test_rn15_wb();
        int lat;
        logic [64:0] got;
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 32'h800, 16'h8001, 0, -1, lat);
        got = (xq.size() > 1) ? xq[1] : '1;
        tests++; if (got !== {1'b1, 32'h804, 32'h0000_1008}) begin fails++; $display("FAIL stm_r15_beat: got %h want 10000080400001008", got); end
        tests++; if (wq.size() != 0 || lat != 3) begin fails++; $display("FAIL rn15_no_wb: got we=%0d lat=%0d want 0 3", wq.size(), lat); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [64:0] got;
        run_op(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h600, 16'h0003, 1, 1, lat);
        tests++; if (xq.size() != 2) begin fails++; $display("FAIL stray_start_beats: got %0d want 2", xq.size()); end
        got = (xq.size() > 1) ? xq[1] : '1;
        tests++; if (got !== {1'b1, 32'h604, 32'hD000_0001}) begin fails++; $display("FAIL stray_start_beat1: got %h want 100000604d0000001", got); end
        tests++; if (lat != 5) begin fails++; $display("FAIL stray_start_latency: got %0d want 5", lat); end
        repeat (3) @(negedge clk);
        #2;
        tests++; if (busy !== 1'b0 || done_cnt != 1) begin fails++; $display("FAIL stray_start_idle: got busy=%b done=%0d want 0 1", busy, done_cnt); end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [35:0] got;
        @(negedge clk); #2;
        clear_logs();
        wait_n = 0;
        is_load = 1'b1; p_bit = 1'b0; u_bit = 1'b1; wback = 1'b0;
        rn = 4'd8; base = 32'h500; reglist = 16'h000F;
        start = 1'b1;
        @(negedge clk); #2;
        start = 1'b0;
        @(negedge clk); #2;
        tests++; if (we !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL abort_pre: got we=%b busy=%b want 1 1", we, busy); end
        reset_n = 1'b0;
        #1;
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL abort_mem_req: got %b want 0", mem_req); end
        tests++; if (we !== 1'b0) begin fails++; $display("FAIL abort_we: got %b want 0", we); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b1;
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 4'd8, 32'h500, 16'h000F, 0, -1, lat);
        tests++; if (wq.size() != 4) begin fails++; $display("FAIL rerun_writes: got %0d want 4", wq.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < wq.size()) ? wq[i] : '1;
            tests++; if (got !== {4'(i), 32'h5A5A_0500 + 32'(4 * i)}) begin fails++; $display("FAIL rerun_load%0d: got %h want %h", i, got, {4'(i), 32'h5A5A_0500 + 32'(4 * i)}); end
        end
        tests++; if (lat != 5) begin fails++; $display("FAIL rerun_latency: got %0d want 5", lat); end
    endtask

    initial begin
        test_reset();
        test_stm_ia_wb();
        test_ldm_db_pc();
        test_ldm_ib_rn_in_list();
        test_empty_list();
        test_wrap();
        test_da_wb();
        test_rn15_wb();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
